// File: rtl/fdd_sd_bridge.sv
// Sector transfer engine between the FDC's SD-style block port and the host
// image byte stream: one 512-byte sector per request, aborts on host stall.
//
// state     | meaning
// IDLE      | waiting for sd_rd/sd_wr
// REQ       | host_req raised, waiting for host_ack
// RD_XFER   | host bytes written into the FDC buffer
// WR_ADDR   | FDC buffer address presented for the next byte
// WR_DATA   | buffer byte offered to the host
// RELEASE   | transfer over, waiting for the FDC to drop its request
module fdd_sd_bridge #(
  parameter logic [23:0] TIMEOUT = 24'd4_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] sd_lba,
  input  logic        sd_rd,
  input  logic        sd_wr,
  output logic        sd_ack,
  output logic [8:0]  sd_buff_addr,
  output logic [7:0]  sd_buff_dout,
  output logic        sd_buff_wr,
  input  logic [7:0]  sd_buff_din,
  output logic        host_req,
  output logic [31:0] host_lba,
  output logic        host_write,
  input  logic        host_ack,
  input  logic [7:0]  host_rd_data,
  input  logic        host_rd_valid,
  output logic [7:0]  host_wr_data,
  output logic        host_wr_valid,
  input  logic        host_wr_ready,
  output logic        xfer_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_RD_XFER, S_WR_ADDR, S_WR_DATA, S_RELEASE
  } state_t;

  state_t      state_q;
  logic [8:0]  cnt_q;
  logic [23:0] prog_q;
  logic        sd_ack_q;
  logic [8:0]  sd_buff_addr_q;
  logic [7:0]  sd_buff_dout_q;
  logic        sd_buff_wr_q;
  logic        host_req_q;
  logic [31:0] host_lba_q;
  logic        host_write_q;
  logic        host_wr_valid_q;
  logic [7:0]  wr_data_q;
  logic        wr_first_q;
  logic        xfer_err_q;

  logic [8:0]  cnt_next_d;
  logic        last_byte_d;
  logic        wr_hs_d;
  logic        progress_d;
  logic        counting_d;
  logic        timeout_hit_d;
  logic        abort_d;

  assign cnt_next_d    = cnt_q + 9'd1;
  assign last_byte_d   = (cnt_q == 9'd511);
  assign wr_hs_d       = host_wr_valid_q & host_wr_ready;
  assign timeout_hit_d = (prog_q == TIMEOUT - 24'd1);

  assign counting_d = (state_q == S_REQ) || (state_q == S_RD_XFER) ||
                      (state_q == S_WR_ADDR) || (state_q == S_WR_DATA);

  // WR_ADDR always leaves after one cycle, so it counts as progress.
  assign progress_d = ((state_q == S_REQ) && host_ack) ||
                      ((state_q == S_RD_XFER) && host_rd_valid) ||
                      (state_q == S_WR_ADDR) ||
                      ((state_q == S_WR_DATA) && wr_hs_d);

  assign abort_d = timeout_hit_d && !progress_d && counting_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      prog_q          <= '0;
      sd_ack_q        <= 1'b0;
      sd_buff_addr_q  <= '0;
      sd_buff_dout_q  <= '0;
      sd_buff_wr_q    <= 1'b0;
      host_req_q      <= 1'b0;
      host_lba_q      <= '0;
      host_write_q    <= 1'b0;
      host_wr_valid_q <= 1'b0;
      wr_data_q       <= '0;
      wr_first_q      <= 1'b0;
      xfer_err_q      <= 1'b0;
    end else begin
      sd_buff_wr_q <= 1'b0;
      xfer_err_q   <= 1'b0;
      wr_first_q   <= 1'b0;
      if (wr_first_q) wr_data_q <= sd_buff_din;

      if (progress_d || !counting_d) prog_q <= '0;
      else                           prog_q <= prog_q + 24'd1;

      if (abort_d) begin
        host_req_q      <= 1'b0;
        host_wr_valid_q <= 1'b0;
        sd_ack_q        <= 1'b0;
        xfer_err_q      <= 1'b1;
        state_q         <= S_RELEASE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (sd_rd || sd_wr) begin
              host_lba_q   <= sd_lba;
              host_write_q <= sd_wr & ~sd_rd;
              cnt_q        <= '0;
              host_req_q   <= 1'b1;
              sd_ack_q     <= 1'b1;
              state_q      <= S_REQ;
            end
          end
          S_REQ: begin
            if (host_ack) begin
              host_req_q     <= 1'b0;
              sd_buff_addr_q <= cnt_q;
              state_q        <= host_write_q ? S_WR_ADDR : S_RD_XFER;
            end
          end
          S_RD_XFER: begin
            if (host_rd_valid) begin
              sd_buff_wr_q   <= 1'b1;
              sd_buff_addr_q <= cnt_q;
              sd_buff_dout_q <= host_rd_data;
              // sd_ack stays up through the final strobe; RELEASE drops it.
              if (last_byte_d) state_q <= S_RELEASE;
              else             cnt_q   <= cnt_next_d;
            end
          end
          S_WR_ADDR: begin
            host_wr_valid_q <= 1'b1;
            wr_first_q      <= 1'b1;
            state_q         <= S_WR_DATA;
          end
          S_WR_DATA: begin
            if (wr_hs_d) begin
              host_wr_valid_q <= 1'b0;
              if (last_byte_d) begin
                sd_ack_q <= 1'b0;
                state_q  <= S_RELEASE;
              end else begin
                cnt_q          <= cnt_next_d;
                sd_buff_addr_q <= cnt_next_d;
                state_q        <= S_WR_ADDR;
              end
            end
          end
          S_RELEASE: begin
            sd_ack_q <= 1'b0;
            if (!sd_rd && !sd_wr) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Buffer data only arrives in the first WR_DATA cycle, so pass it straight
  // through then and serve the captured copy while the host stalls.
  assign host_wr_data  = wr_first_q ? sd_buff_din : wr_data_q;

  assign sd_ack        = sd_ack_q;
  assign sd_buff_addr  = sd_buff_addr_q;
  assign sd_buff_dout  = sd_buff_dout_q;
  assign sd_buff_wr    = sd_buff_wr_q;
  assign host_req      = host_req_q;
  assign host_lba      = host_lba_q;
  assign host_write    = host_write_q;
  assign host_wr_valid = host_wr_valid_q;
  assign xfer_err      = xfer_err_q;

endmodule

// File: tb/tb_fdd_sd_bridge.sv
// Directed bench for fdd_sd_bridge: table of sector requests plus hand-written
// retrigger, timeout and mid-transfer reset sequences.
module tb_fdd_sd_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic        host_req;
  logic [31:0] host_lba;
  logic        host_write;
  logic        host_ack;
  logic [7:0]  host_rd_data;
  logic        host_rd_valid;
  logic [7:0]  host_wr_data;
  logic        host_wr_valid;
  logic        host_wr_ready;
  logic        xfer_err;

  always #5 clk = ~clk;

  fdd_sd_bridge #(.TIMEOUT(24'd100)) dut (
    .clk(clk), .reset(reset),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .host_req(host_req), .host_lba(host_lba), .host_write(host_write),
    .host_ack(host_ack), .host_rd_data(host_rd_data),
    .host_rd_valid(host_rd_valid), .host_wr_data(host_wr_data),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .xfer_err(xfer_err)
  );

  // FDC sector buffer: synchronous read, data one cycle after the address.
  logic [7:0] fdc_mem [512];
  always @(posedge clk) sd_buff_din <= fdc_mem[sd_buff_addr];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] lba;
    logic        exp_write;
  } vec_t;

  vec_t vecs [3];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {1'b0, sd_ack, sd_buff_wr, sd_buff_addr, sd_buff_dout, host_req,
            host_lba, host_write, host_wr_valid, host_wr_data, xfer_err};
  endfunction

  task automatic start_req(input logic rd, input logic wr, input logic [31:0] lba,
                           input logic exp_w);
    sd_rd  = rd;
    sd_wr  = wr;
    sd_lba = lba;
    tick();
    check("accept_ack", 64'(sd_ack), 64'd1);
    check("accept_req", 64'(host_req), 64'd1);
    check("host_lba", 64'(host_lba), 64'(lba));
    check("host_write", 64'(host_write), 64'(exp_w));
    sd_lba = 32'hDEAD_BEEF;
  endtask

  task automatic host_accept(input logic [31:0] lba);
    int bad = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (host_req !== 1'b1) bad++;
    end
    check("req_held", 64'(bad), 64'd0);
    check("lba_latched", 64'(host_lba), 64'(lba));
    host_ack = 1'b1;
    tick();
    host_ack = 1'b0;
    check("req_drop", 64'(host_req), 64'd0);
  endtask

  task automatic stream_read();
    int bad = 0;
    logic [7:0] exp_b;
    for (int i = 0; i < 512; i++) begin
      exp_b         = 8'(i) ^ 8'h5A;
      host_rd_valid = 1'b1;
      host_rd_data  = exp_b;
      tick();
      if (!(sd_buff_wr === 1'b1 && sd_buff_addr === 9'(i) && sd_buff_dout === exp_b)) bad++;
    end
    host_rd_valid = 1'b0;
    check("rd_strobes", 64'(bad), 64'd0);
    check("rd_ack_at_last", 64'(sd_ack), 64'd1);
    tick();
    check("rd_ack_fall", 64'(sd_ack), 64'd0);
    check("rd_no_extra_wr", 64'(sd_buff_wr), 64'd0);
  endtask

  task automatic stream_write(input int stop_at, output int got);
    int n = 0, bad = 0, cyc = 0;
    while (n < stop_at && cyc < 6000) begin
      host_wr_ready = 1'($urandom_range(0, 1));
      if (host_wr_valid === 1'b1 && host_wr_ready) begin
        if (host_wr_data !== 8'(n)) bad++;
        n++;
      end
      tick();
      cyc++;
    end
    host_wr_ready = 1'b0;
    got = n;
    check("wr_data", 64'(bad), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, bad, cyc, extra;

    vecs[0] = '{rd: 1'b1, wr: 1'b0, lba: 32'h0000_01C5, exp_write: 1'b0};
    vecs[1] = '{rd: 1'b0, wr: 1'b1, lba: 32'h0000_0007, exp_write: 1'b1};
    vecs[2] = '{rd: 1'b1, wr: 1'b1, lba: 32'h0000_02AB, exp_write: 1'b0};
    for (int a = 0; a < 512; a++) fdc_mem[a] = 8'(a);

    reset = 1'b1; sd_lba = '0; sd_rd = 1'b0; sd_wr = 1'b0;
    host_ack = 1'b0; host_rd_data = '0; host_rd_valid = 1'b0; host_wr_ready = 1'b0;
    repeat (3) tick();
    check("reset_state", all_outs(), 64'd0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 3; v++) begin
      start_req(vecs[v].rd, vecs[v].wr, vecs[v].lba, vecs[v].exp_write);
      host_accept(vecs[v].lba);
      if (vecs[v].exp_write) begin
        stream_write(512, got);
        check("wr_count", 64'(got), 64'd512);
        check("wr_end_ack", 64'(sd_ack), 64'd0);
        check("wr_end_valid", 64'(host_wr_valid), 64'd0);
      end else begin
        stream_read();
      end
      sd_rd = 1'b0; sd_wr = 1'b0;
      tick(); tick();
    end

    // Request level held after the transfer must not retrigger.
    start_req(1'b1, 1'b0, 32'h10, 1'b0);
    host_accept(32'h10);
    stream_read();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (host_req !== 1'b0 || sd_ack !== 1'b0) bad++;
    end
    check("no_retrigger", 64'(bad), 64'd0);
    sd_rd = 1'b0;
    tick(); tick();
    start_req(1'b1, 1'b0, 32'h11, 1'b0);
    sd_rd = 1'b0;
    host_accept(32'h11);
    stream_read();
    tick(); tick();

    // Host stalls after 10 bytes: abort 100 cycles after the last strobe.
    start_req(1'b1, 1'b0, 32'h33, 1'b0);
    host_accept(32'h33);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      host_rd_valid = 1'b1;
      host_rd_data  = 8'(i + 16);
      tick();
      if (!(sd_buff_wr === 1'b1 && sd_buff_addr === 9'(i) && sd_buff_dout === 8'(i + 16))) bad++;
    end
    host_rd_valid = 1'b0;
    check("to_bytes", 64'(bad), 64'd0);
    cyc = 0; extra = 0;
    while (xfer_err !== 1'b1 && cyc < 300) begin
      tick();
      cyc++;
      if (sd_buff_wr !== 1'b0) extra++;
    end
    check("timeout_cycles", 64'(cyc), 64'd100);
    check("timeout_ack", 64'(sd_ack), 64'd0);
    check("timeout_req", 64'(host_req), 64'd0);
    check("timeout_no_wr", 64'(extra), 64'd0);
    host_rd_valid = 1'b1;
    host_rd_data  = 8'hEE;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (sd_buff_wr !== 1'b0 || xfer_err !== 1'b0) bad++;
    end
    check("release_ignore", 64'(bad), 64'd0);
    host_rd_valid = 1'b0;
    sd_rd = 1'b0;
    tick(); tick();

    // Reset after 200 write bytes, then a clean write.
    start_req(1'b0, 1'b1, 32'h200, 1'b1);
    host_accept(32'h200);
    stream_write(200, got);
    check("wr_partial_count", 64'(got), 64'd200);
    reset = 1'b1;
    sd_wr = 1'b0;
    tick();
    check("reset_mid_write", all_outs(), 64'd0);
    reset = 1'b0;
    tick();
    check("after_reset_idle", all_outs(), 64'd0);
    start_req(1'b0, 1'b1, 32'h201, 1'b1);
    host_accept(32'h201);
    stream_write(512, got);
    check("wr2_count", 64'(got), 64'd512);
    check("wr2_end_ack", 64'(sd_ack), 64'd0);
    sd_wr = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fdd_sd_bridge.md
# fdd_sd_bridge

Sector transfer engine between the floppy controller's SD-style block port (`sd_lba`/`sd_rd`/`sd_wr`/`sd_ack`/`sd_buff_*`) and the host image-storage byte stream. It accepts one 512-byte sector request at a time from the FDC cartridge, forwards the LBA and direction to the host side, and moves bytes between the host stream and the FDC's sector buffer. It raises `sd_ack` for the duration of the transfer, and it aborts cleanly on host stall.

## Interface
Parameters:
- `TIMEOUT`, default 24'd4_000_000: number of `clk` cycles without forward progress before a transfer is aborted.

Ports:
- `clk`  in  1  system clock; all logic is clocked on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sd_lba`  in  32  sector number from the FDC; sampled at request accept.
- `sd_rd`  in  1  FDC read request, level.
- `sd_wr`  in  1  FDC write request, level.
- `sd_ack`  out  1  high from request accept until transfer end.
- `sd_buff_addr`  out  9  byte index into the FDC sector buffer.
- `sd_buff_dout`  out  8  read byte toward the FDC buffer.
- `sd_buff_wr`  out  1  one-cycle write strobe into the FDC buffer.
- `sd_buff_din`  in  8  FDC buffer byte at `sd_buff_addr`, valid one cycle after the address.
- `host_req`  out  1  sector request to the host, held until `host_ack`.
- `host_lba`  out  32  latched LBA.
- `host_write`  out  1  1 = write sector, 0 = read sector; latched.
- `host_ack`  in  1  one-cycle pulse: host accepted the request.
- `host_rd_data`  in  8  host read byte.
- `host_rd_valid`  in  1  `host_rd_data` is valid this cycle.
- `host_wr_data`  out  8  byte to the host.
- `host_wr_valid`  out  1  `host_wr_data` is valid.
- `host_wr_ready`  in  1  host consumes the byte when both valid and ready are high.
- `xfer_err`  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, REQ, RD_XFER, WR_ADDR, WR_DATA, RELEASE.
- IDLE: on `sd_rd|sd_wr`, latch `sd_lba` into `host_lba` and set `host_write = sd_wr & ~sd_rd`. Read has priority if both are high. Clear the byte counter, set `host_req` and `sd_ack`, and go to REQ.
- REQ: hold `host_req`. On `host_ack`, drop `host_req` and go to RD_XFER if reading, otherwise WR_ADDR.
- RD_XFER: each `host_rd_valid` produces one buffer write: `sd_buff_addr` = counter, `sd_buff_dout` = byte, `sd_buff_wr` = 1, then the counter increments. The write at counter 511 ends the transfer and goes to RELEASE.
- WR_ADDR: drive `sd_buff_addr` = counter for one cycle, then go to WR_DATA.
- WR_DATA: capture `sd_buff_din` into `host_wr_data` on entry and assert `host_wr_valid`. Hold both until `host_wr_ready`. On the handshake, if the counter is 511 go to RELEASE; otherwise increment the counter and return to WR_ADDR.
- RELEASE: `sd_ack` is 0. Stay until `sd_rd` and `sd_wr` are both low, then go to IDLE. This blocks re-triggering on a request level the FDC has not yet dropped.
- Counter: 9 bits, never wraps inside a transfer. It is reset only on request accept.
- Timeout: a progress counter clears on every state change and on every data handshake. It counts otherwise in REQ, RD_XFER, WR_ADDR and WR_DATA. When it reaches `TIMEOUT`:
  - drop `host_req` and `host_wr_valid`;
  - pulse `xfer_err`;
  - go to RELEASE.
  - On a read abort, remaining buffer bytes are not written.
- While in RELEASE, `host_rd_valid` is ignored.
- Reset values: `sd_ack`=0, `sd_buff_wr`=0, `sd_buff_addr`=0, `sd_buff_dout`=0, `host_req`=0, `host_lba`=0, `host_write`=0, `host_wr_valid`=0, `host_wr_data`=0, `xfer_err`=0; state = IDLE.
- Reset mid-transfer: same values next cycle, with no further buffer writes or host strobes.

## Timing
- Accept: request high in IDLE at cycle N gives `sd_ack`=1 and `host_req`=1 at N+1.
- `host_ack` at cycle M drops `host_req` at M+1.
- Read byte: `host_rd_valid` at cycle K gives `sd_buff_wr` high with data and address at K+1. Back-to-back valids are accepted every cycle. The transfer takes a minimum of 512 cycles.
- Last read byte: `sd_buff_wr` at cycle K+1, `sd_ack`=0 at K+2.
- Write byte: address at cycle A, `host_wr_valid` at A+1. Fastest rate is one byte per 2 cycles.
- Last write handshake at cycle H gives `sd_ack`=0 at H+1.
- `xfer_err` is a single cycle, coincident with the first cycle of RELEASE.

## Test plan
- Read: `sd_rd`=1 with `sd_lba`=0x1C5, host acks after 3 cycles, then streams bytes `i^0x5A` every cycle. Required: `host_lba`=0x1C5 and `host_write`=0; 512 `sd_buff_wr` strobes at addresses 0..511 with matching data; `sd_ack` falls one cycle after the last strobe.
- Write: `sd_wr`=1 with `sd_lba`=7 and FDC buffer model `din[a]=a[7:0]`; `host_wr_ready` toggles randomly. Required: the host receives exactly 512 bytes 0x00..0xFF,0x00..0xFF in order; `host_write`=1.
- Simultaneous `sd_rd` and `sd_wr` -> read is performed (`host_write`=0).
- `sd_rd` held high 20 cycles after the transfer ends -> no second `host_req` until `sd_rd` drops. Then a new `sd_rd` pulse -> new request.
- Timeout with `TIMEOUT`=100: host stops after 10 bytes -> `xfer_err` pulses once 100 cycles later, `sd_ack`=0, and no further `sd_buff_wr`.
- Reset asserted at byte 200 of a write -> all outputs take reset values next cycle; a subsequent request completes normally.
